// File: rtl/branch_ctrl.sv
// Branch-resolution controller for the EX stage.
// Owns the architectural flags, resolves branches against them, issues a
// registered one-cycle PC redirect and squashes wrong-path work for
// FLUSH_CYCLES non-stalled cycles afterwards.
module branch_ctrl #(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_in,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [1:0]       ex_cond,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             ex_setflags,
    input  logic [3:0]       alu_flags,
    output logic [3:0]       flags,
    output logic             pc_src,
    output logic [PC_W-1:0]  pc_target,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int CW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [1:0] C_B   = 2'b00;
    localparam logic [1:0] C_BEQ = 2'b01;
    localparam logic [1:0] C_BGT = 2'b10;
    localparam logic [1:0] C_BLT = 2'b11;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic squash, act, cond_true, resolve, taken;

    // flags bit order: {carry, neg, zero, overflow}
    logic f_neg, f_zero;
    assign f_neg  = flags[2];
    assign f_zero = flags[1];

    assign squash  = (state == FLUSH) | pc_src;
    assign act     = ex_valid & ~squash & ~stall_in;
    assign resolve = act & ex_branch;
    assign taken   = resolve & cond_true;
    assign flush   = (state == FLUSH);

    // condition evaluation against the registered flags, never alu_flags
    always_comb begin
        cond_true = 1'b0;
        case (ex_cond)
            C_B:     cond_true = 1'b1;
            C_BEQ:   cond_true = f_zero;
            C_BGT:   cond_true = ~f_neg & ~f_zero;
            C_BLT:   cond_true = f_neg;
            default: cond_true = 1'b0;
        endcase
    end

    // FSM state and flush counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // next state: count down only on non-stalled cycles, leave FLUSH at 1
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (taken) begin
                    state_n = FLUSH;
                    cnt_n   = CW'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (!stall_in) begin
                    if (cnt == CW'(1)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // flags, redirect and saturating statistics
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags      <= '0;
            pc_src     <= 1'b0;
            pc_target  <= '0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            // branches never write flags, even with setflags set
            if (act && ex_setflags && !ex_branch)
                flags <= alu_flags;
            // pc_src holds through stalls, drops after the first free cycle;
            // taken cannot fire while pc_src is high because it squashes
            if (!stall_in)
                pc_src <= taken;
            if (taken)
                pc_target <= ex_target;
            if (resolve && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (taken && (taken_cnt != '1))
                taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end

endmodule
